// File: rtl/gpioemu_host_if.sv
// Request/response and slave-bus bundle for gpioemu_host.
// master = the host block, slave = request source plus gpioemu peripheral.
interface gpioemu_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_prime;
  logic [1:0]  rsp_err;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;
  logic [31:0] done_cnt;
  logic        busy;

  modport master (
    input  req_valid, req_n, rsp_ready, sdata_in, done_cnt,
    output req_ready, rsp_valid, rsp_prime, rsp_err, saddress, srd, swr, sdata_out, busy
  );

  modport slave (
    output req_valid, req_n, rsp_ready, sdata_in, done_cnt,
    input  req_ready, rsp_valid, rsp_prime, rsp_err, saddress, srd, swr, sdata_out, busy
  );
endinterface

// File: rtl/gpioemu_host.sv
// Initiator for the gpioemu prime peripheral: write A, wait for done_cnt, read S and W, cache last result.
// Optional WAIT_DONE timeout enabled by defining GPIOEMU_HOST_TIMEOUT_EN.
module gpioemu_host #(
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           n_reset,
  gpioemu_host_if.master bus
);
  localparam logic [15:0] ADDR_A   = 16'h00D4;
  localparam logic [15:0] ADDR_S   = 16'h00EC;
  localparam logic [15:0] ADDR_W   = 16'h00E4;
  localparam logic [31:0] ST_OK    = 32'h0000_00AA;
  localparam logic [31:0] N_MAX    = 32'd1000;
  localparam logic [15:0] BUS_LAST = 16'(STROBE_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_WRITE_A = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_READ_S  = 3'd4;
  localparam logic [2:0] S_READ_W  = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  if (STROBE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("gpioemu_host: STROBE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  logic [2:0]  r_state;
  logic [15:0] r_bcnt;
  logic [31:0] r_n;
  logic [31:0] r_cnt_ref;
  logic        r_c_vld;
  logic [31:0] r_c_n;
  logic [31:0] r_c_prime;
  logic        r_rsp_valid;
  logic [31:0] r_prime;
  logic [1:0]  r_err;
  logic [15:0] r_saddr;
  logic [31:0] r_sdata;
  logic        r_srd;
  logic        r_swr;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
  logic [31:0] r_to_cnt;
`endif

  logic [2:0]  w_state_nx;
  logic [15:0] w_bcnt_nx;
  logic        w_bus_last;
  logic        w_bus_st_nx;
  logic        w_stb_nx;
  logic        w_ld;
  logic [31:0] w_prime_nx;
  logic [1:0]  w_err_nx;
  logic        w_c_inv;
  logic        w_c_ld;
  logic [15:0] w_addr_nx;

  assign w_bus_last = (r_bcnt == BUS_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_ld       = 1'b0;
    w_prime_nx = '0;
    w_err_nx   = 2'd0;
    w_c_inv    = 1'b0;
    w_c_ld     = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.req_valid) w_state_nx = S_CHECK;
      S_CHECK: begin
        if (r_n == '0 || r_n > N_MAX) begin
          w_state_nx = S_RESP;
          w_ld       = 1'b1;
          w_err_nx   = 2'd1;
        end else if (r_c_vld && r_n == r_c_n) begin
          w_state_nx = S_RESP;
          w_ld       = 1'b1;
          w_prime_nx = r_c_prime;
        end else begin
          w_state_nx = S_WRITE_A;
        end
      end
      S_WRITE_A: if (w_bus_last) w_state_nx = S_WAIT;
      S_WAIT: begin
        // Inequality only, so a wrap of done_cnt still counts as completion
        if (bus.done_cnt != r_cnt_ref) w_state_nx = S_READ_S;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
        else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_state_nx = S_RESP;
          w_ld       = 1'b1;
          w_err_nx   = 2'd2;
          w_c_inv    = 1'b1;
        end
`endif
      end
      S_READ_S: begin
        if (w_bus_last) begin
          if (bus.sdata_in != ST_OK) begin
            w_state_nx = S_RESP;
            w_ld       = 1'b1;
            w_err_nx   = 2'd3;
            w_c_inv    = 1'b1;
          end else begin
            w_state_nx = S_READ_W;
          end
        end
      end
      S_READ_W: begin
        if (w_bus_last) begin
          w_state_nx = S_RESP;
          w_ld       = 1'b1;
          w_prime_nx = bus.sdata_in;
          w_c_ld     = 1'b1;
        end
      end
      S_RESP:    if (r_rsp_valid && bus.rsp_ready) w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  // Bus outputs are registered from next-state so the slave sees glitch-free strobes
  always_comb begin
    w_bus_st_nx = (w_state_nx == S_WRITE_A) || (w_state_nx == S_READ_S) || (w_state_nx == S_READ_W);
    w_bcnt_nx   = (w_bus_st_nx && w_state_nx == r_state) ? r_bcnt + 16'd1 : 16'd0;
    w_stb_nx    = w_bus_st_nx && (w_bcnt_nx != 16'd0) && (w_bcnt_nx != BUS_LAST);
    case (w_state_nx)
      S_WRITE_A: w_addr_nx = ADDR_A;
      S_READ_S:  w_addr_nx = ADDR_S;
      S_READ_W:  w_addr_nx = ADDR_W;
      default:   w_addr_nx = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_n         <= '0;
      r_cnt_ref   <= '0;
      r_c_vld     <= 1'b0;
      r_c_n       <= '0;
      r_c_prime   <= '0;
      r_rsp_valid <= 1'b0;
      r_prime     <= '0;
      r_err       <= '0;
      r_saddr     <= '0;
      r_sdata     <= '0;
      r_srd       <= 1'b0;
      r_swr       <= 1'b0;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_bcnt  <= w_bcnt_nx;
      if (r_state == S_IDLE && bus.req_valid) r_n <= bus.req_n;
      if (r_state == S_CHECK) r_cnt_ref <= bus.done_cnt;
      if (w_ld) begin
        r_prime <= w_prime_nx;
        r_err   <= w_err_nx;
      end
      if (w_c_inv) r_c_vld <= 1'b0;
      else if (w_c_ld) begin
        r_c_vld   <= 1'b1;
        r_c_n     <= r_n;
        r_c_prime <= bus.sdata_in;
      end
      r_rsp_valid <= (r_state == S_RESP) && !(r_rsp_valid && bus.rsp_ready);
      r_saddr     <= w_addr_nx;
      r_sdata     <= (w_state_nx == S_WRITE_A) ? r_n : 32'd0;
      r_swr       <= w_stb_nx && (w_state_nx == S_WRITE_A);
      r_srd       <= w_stb_nx && (w_state_nx != S_WRITE_A);
`ifdef GPIOEMU_HOST_TIMEOUT_EN
      r_to_cnt    <= (r_state == S_WAIT && w_state_nx == S_WAIT) ? r_to_cnt + 32'd1 : 32'd0;
`endif
    end
  end

  assign bus.req_ready = (r_state == S_IDLE) && n_reset;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_prime = r_prime;
  assign bus.rsp_err   = r_err;
  assign bus.saddress  = r_saddr;
  assign bus.sdata_out = r_sdata;
  assign bus.srd       = r_srd;
  assign bus.swr       = r_swr;
endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host with a small behavioural gpioemu slave attached.
module tb_gpioemu_host;
  logic clk;
  logic n_reset;
  gpioemu_host_if bus();

  gpioemu_host #(.STROBE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave model: accepts a new A on a rising swr, bumps done_cnt a few cycles later
  logic        s_q;
  logic [31:0] last_a;
  logic [31:0] w_reg;
  logic [3:0]  pend;
  logic        freeze = 1'b0;
  logic        bad_st = 1'b0;

  function automatic logic [31:0] nth_prime(input logic [31:0] n);
    int cnt = 0;
    int v   = 1;
    bit isp;
    while (cnt < int'(n)) begin
      v++;
      isp = 1'b1;
      for (int d = 2; d * d <= v; d++) if (v % d == 0) begin isp = 1'b0; break; end
      if (isp) cnt++;
    end
    return 32'(v);
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s_q <= 1'b0; last_a <= '0; w_reg <= '0; pend <= '0; bus.done_cnt <= '0;
    end else begin
      s_q <= bus.swr;
      if (pend != 0) begin
        pend <= pend - 4'd1;
        if (pend == 4'd1) bus.done_cnt <= bus.done_cnt + 32'd1;
      end
      if (bus.swr && !s_q && bus.saddress == 16'h00D4 && bus.sdata_out != last_a) begin
        last_a <= bus.sdata_out;
        w_reg  <= nth_prime(bus.sdata_out);
        if (!freeze) pend <= 4'd4;
      end
    end
  end

  always_comb begin
    bus.sdata_in = 32'd0;
    if (bus.saddress == 16'h00EC) bus.sdata_in = bad_st ? 32'h55 : 32'hAA;
    else if (bus.saddress == 16'h00E4) bus.sdata_in = w_reg;
  end

  // Bus observers
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          ovl    = 0;
  logic [15:0] wr_addr, rd_last, rd_prev;
  logic [31:0] wr_data;
  always @(posedge bus.swr) begin wr_cnt++; wr_addr = bus.saddress; wr_data = bus.sdata_out; end
  always @(posedge bus.srd) begin rd_cnt++; rd_prev = rd_last; rd_last = bus.saddress; end
  always @(negedge clk) if (bus.srd && bus.swr) ovl++;

  task automatic do_req(input logic [31:0] n, output logic [31:0] p, output logic [1:0] e, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_n = n;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = c; break; end
    end
    p = bus.rsp_prime; e = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    total += 9;
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b exp=0", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    if (bus.rsp_prime !== 32'd0) begin bad++; $display("FAIL rst_rsp_prime got=%0h exp=0", bus.rsp_prime); end
    if (bus.rsp_err !== 2'd0) begin bad++; $display("FAIL rst_rsp_err got=%0d exp=0", bus.rsp_err); end
    if (bus.saddress !== 16'd0) begin bad++; $display("FAIL rst_saddress got=%0h exp=0", bus.saddress); end
    if (bus.srd !== 1'b0) begin bad++; $display("FAIL rst_srd got=%0b exp=0", bus.srd); end
    if (bus.swr !== 1'b0) begin bad++; $display("FAIL rst_swr got=%0b exp=0", bus.swr); end
    if (bus.sdata_out !== 32'd0) begin bad++; $display("FAIL rst_sdata_out got=%0h exp=0", bus.sdata_out); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    n_reset = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b exp=1", bus.req_ready); end
  endtask

  task automatic test_miss_n1();
    logic [31:0] p; logic [1:0] e; int lat; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    do_req(32'd1, p, e, lat);
    total += 8;
    if (p !== 32'd2) begin bad++; $display("FAIL n1_prime got=%0d exp=2", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL n1_err got=%0d exp=0", e); end
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL n1_writes got=%0d exp=1", wr_cnt - w0); end
    if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL n1_reads got=%0d exp=2", rd_cnt - r0); end
    if (wr_addr !== 16'h00D4) begin bad++; $display("FAIL n1_wr_addr got=%0h exp=d4", wr_addr); end
    if (wr_data !== 32'd1) begin bad++; $display("FAIL n1_wr_data got=%0h exp=1", wr_data); end
    if (rd_prev !== 16'h00EC) begin bad++; $display("FAIL n1_rd_s_addr got=%0h exp=ec", rd_prev); end
    if (rd_last !== 16'h00E4) begin bad++; $display("FAIL n1_rd_w_addr got=%0h exp=e4", rd_last); end
  endtask

  task automatic test_n1000();
    logic [31:0] p; logic [1:0] e; int lat; logic [31:0] d0;
    d0 = bus.done_cnt;
    do_req(32'd1000, p, e, lat);
    total += 3;
    if (p !== 32'h1EEF) begin bad++; $display("FAIL n1000_prime got=%0d exp=7919", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL n1000_err got=%0d exp=0", e); end
    if (bus.done_cnt - d0 !== 32'd1) begin bad++; $display("FAIL n1000_done_cnt got=%0d exp=1", bus.done_cnt - d0); end
  endtask

  task automatic test_cache_hit();
    logic [31:0] p; logic [1:0] e; int lat; int s0;
    s0 = wr_cnt + rd_cnt;
    do_req(32'd1000, p, e, lat);
    total += 5;
    if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    if (p !== 32'd7919) begin bad++; $display("FAIL hit_prime got=%0d exp=7919", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL hit_err got=%0d exp=0", e); end
    if (wr_cnt + rd_cnt - s0 !== 0) begin bad++; $display("FAIL hit_strobes got=%0d exp=0", wr_cnt + rd_cnt - s0); end
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL hit_idle_after got=%0b exp=1", bus.req_ready); end
  endtask

  task automatic test_range();
    logic [31:0] p; logic [1:0] e; int lat; int s0, w0;
    logic [31:0] ns [2] = '{32'd0, 32'd1001};
    s0 = wr_cnt + rd_cnt;
    for (int i = 0; i < 2; i++) begin
      do_req(ns[i], p, e, lat);
      total += 3;
      if (e !== 2'd1) begin bad++; $display("FAIL range_err n=%0d got=%0d exp=1", ns[i], e); end
      if (p !== 32'd0) begin bad++; $display("FAIL range_prime n=%0d got=%0d exp=0", ns[i], p); end
      if (lat !== 2) begin bad++; $display("FAIL range_latency n=%0d got=%0d exp=2", ns[i], lat); end
    end
    total++;
    if (wr_cnt + rd_cnt - s0 !== 0) begin bad++; $display("FAIL range_strobes got=%0d exp=0", wr_cnt + rd_cnt - s0); end
    w0 = wr_cnt;
    do_req(32'd5, p, e, lat);
    total += 3;
    if (p !== 32'd11) begin bad++; $display("FAIL n5_prime got=%0d exp=11", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL n5_err got=%0d exp=0", e); end
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL n5_writes got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] p; int w0; bit seen;
    w0 = wr_cnt; seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_n = 32'd7;
    @(posedge clk);
    #1 bus.req_n = 32'd9;
    repeat (3) @(negedge clk);
    total += 2;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_flag got=%0b exp=1", bus.busy); end
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%0b exp=0", bus.req_ready); end
    for (int c = 0; c < 3000; c++) begin
      if (bus.rsp_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    p = bus.rsp_prime;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    total += 4;
    if (seen !== 1'b1) begin bad++; $display("FAIL busy_rsp_seen got=%0b exp=1", seen); end
    if (p !== 32'd17) begin bad++; $display("FAIL busy_prime got=%0d exp=17", p); end
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL busy_writes got=%0d exp=1", wr_cnt - w0); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_bad_status();
    logic [31:0] p; logic [1:0] e; int lat;
    bad_st = 1'b1;
    do_req(32'd13, p, e, lat);
    bad_st = 1'b0;
    total += 2;
    if (e !== 2'd3) begin bad++; $display("FAIL badst_err got=%0d exp=3", e); end
    if (p !== 32'd0) begin bad++; $display("FAIL badst_prime got=%0d exp=0", p); end
    do_req(32'd6, p, e, lat);
    total += 2;
    if (p !== 32'd13) begin bad++; $display("FAIL n6_prime got=%0d exp=13", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL n6_err got=%0d exp=0", e); end
  endtask

`ifdef GPIOEMU_HOST_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] p; logic [1:0] e; int lat; int w0;
    freeze = 1'b1;
    do_req(32'd21, p, e, lat);
    total += 3;
    if (e !== 2'd2) begin bad++; $display("FAIL to_err got=%0d exp=2", e); end
    if (p !== 32'd0) begin bad++; $display("FAIL to_prime got=%0d exp=0", p); end
    if (lat !== 70) begin bad++; $display("FAIL to_latency got=%0d exp=70", lat); end
    freeze = 1'b0;
    w0 = wr_cnt;
    do_req(32'd21, p, e, lat);
    total += 2;
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL to_rewrite got=%0d exp=1", wr_cnt - w0); end
    if (e !== 2'd2) begin bad++; $display("FAIL to_rewrite_err got=%0d exp=2", e); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] p; logic [1:0] e; int lat; int w0; bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_n = 32'd3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.swr) begin seen = 1'b1; break; end
    end
    #2 n_reset = 1'b0;
    #1;
    total += 5;
    if (seen !== 1'b1) begin bad++; $display("FAIL rmid_swr_seen got=%0b exp=1", seen); end
    if (bus.swr !== 1'b0) begin bad++; $display("FAIL rmid_swr got=%0b exp=0", bus.swr); end
    if (bus.saddress !== 16'd0) begin bad++; $display("FAIL rmid_saddress got=%0h exp=0", bus.saddress); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", bus.busy); end
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_rst got=%0b exp=0", bus.req_ready); end
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%0b exp=1", bus.req_ready); end
    w0 = wr_cnt;
    do_req(32'd3, p, e, lat);
    total += 3;
    if (p !== 32'd5) begin bad++; $display("FAIL rmid_prime got=%0d exp=5", p); end
    if (e !== 2'd0) begin bad++; $display("FAIL rmid_err got=%0d exp=0", e); end
    if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL rmid_writes got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_overlap();
    total++;
    if (ovl !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", ovl); end
  endtask

  initial begin
    n_reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_n = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_miss_n1();
    test_n1000();
    test_cache_hit();
    test_range();
    test_busy_ignore();
    test_bad_status();
`ifdef GPIOEMU_HOST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpioemu_host.md
# gpioemu_host

Bus initiator that drives the gpioemu register interface from the initiator side. It accepts a prime-index request N over a valid/ready handshake, then runs the peripheral's sequence: write A, wait for completion, read S, read W. It returns the N-th prime with an error code, and caches the last good result so a repeated N produces no bus traffic. It sits between a host-side request source and the gpioemu slave port, on the same `clk`.

## Interface
- `STROBE_CYCLES`, default 2: clock cycles that `srd`/`swr` stay high per transaction (min 1).
- `TIMEOUT_CYCLES`, default 65535: maximum cycles spent in WAIT_DONE (only with the timeout macro).
- `clk`  in  1  sole clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_n`  in  32  requested prime index N.
- `rsp_valid`  out  1  response valid; held until `rsp_ready`.
- `rsp_ready`  in  1  response accept.
- `rsp_prime`  out  32  N-th prime (0 on error).
- `rsp_err`  out  2  0 ok, 1 range, 2 timeout, 3 bad status.
- `saddress`  out  16  register address to slave.
- `srd` / `swr`  out  1  read/write strobes; slave is rising-edge sensitive.
- `sdata_out`  out  32  write data to slave `sdata_in`.
- `sdata_in`  in  32  read data from slave `sdata_out`.
- `done_cnt`  in  32  slave `gpio_out`; increments once per completed computation.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Register map (fixed localparams): A = 0xD4 (write), S = 0xEC (read), W = 0xE4 (read); slave idle status = 0xAA.
- States: IDLE → CHECK → {RESP | WRITE_A} → WAIT_DONE → READ_S → READ_W → RESP → IDLE.
- IDLE: on `req_valid && req_ready`, latch N and go to CHECK.
- CHECK:
  - N == 0 or N > 1000 → err 1, prime 0, no bus activity.
  - Else, if cache valid and N == cached N → err 0, prime = cached prime, no bus activity.
  - Else capture `done_cnt` into `cnt_ref` and go to WRITE_A.
- WRITE_A: one write transaction to 0xD4 with data N.
- WAIT_DONE: stay until `done_cnt != cnt_ref` (sampled each cycle), then go to READ_S.
- READ_S: read 0xEC. If the value ≠ 0xAA → err 3, prime 0, cache invalidated, go to RESP.
- READ_W: read 0xE4. Store the result in `rsp_prime`, set err 0, load cache {N, prime, valid=1}.
- RESP: `rsp_valid` high until `rsp_ready`; then go to IDLE.
- Bus transaction (shared sub-sequencer), STROBE_CYCLES+2 cycles:
  - SETUP, 1 cycle: `saddress`/`sdata_out` driven, strobes low.
  - STROBE, STROBE_CYCLES cycles: strobe high.
  - HOLD, 1 cycle: strobe low, address held; read data captured from `sdata_in` at the clock edge ending HOLD.
- Outside transactions: `saddress` = 0, `sdata_out` = 0, strobes low. `srd` and `swr` are never high together.
- Cache invalidation rationale: the slave ignores a write equal to its last accepted A, so the cache must track it. Both blocks reset together, and the slave's last A resets to 0, which is never a legal N.

## Timing
- Reset values (asynchronous, immediate): `req_ready` 0 during reset and 1 after release; `rsp_valid` 0, `rsp_prime` 0, `rsp_err` 0, `saddress` 0, `srd` 0, `swr` 0, `sdata_out` 0, `busy` 0. Cache invalid, state IDLE.
- Reset mid-transaction: strobes drop in the same instant; the partial transaction is abandoned with no retry.
- Range or cache-hit path: request accepted at edge 0, `rsp_valid` high after edge 2.
- Miss path: 2 + (STROBE_CYCLES+2) + wait + 2·(STROBE_CYCLES+2) + 1 cycles to `rsp_valid`.
- `req_valid` asserted while busy: ignored (`req_ready` = 0); no queueing.
- `rsp_ready` held high: response consumed in its first valid cycle; IDLE on the next cycle.
- `done_cnt` wrap-around: inequality compare only, so 0xFFFFFFFF → 0 counts as completion.

## Configuration
- `GPIOEMU_HOST_TIMEOUT_EN` defined:
  - A 32-bit counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES → err 2, prime 0, cache invalidated, go to RESP, skipping READ_S and READ_W.
- Not defined: WAIT_DONE waits indefinitely, err 2 is never produced, and the counter is absent.

## Test plan
- N=1, slave model attached → one `swr` at 0xD4 with data 1, then `srd` at 0xEC (0xAA), then `srd` at 0xE4 → `rsp_prime` 2, err 0.
- N=1000 → `rsp_prime` 7919 (0x1EEF), err 0; `done_cnt` +1.
- Repeat N=1000 immediately → `rsp_valid` 2 cycles after accept, prime 7919, zero strobes observed.
- N=0, then N=1001 → err 1, prime 0 for each, no strobes; next N=5 performs the full sequence → 11.
- Timeout macro on, TIMEOUT_CYCLES=64, `done_cnt` frozen → err 2 exactly 64 cycles after entering WAIT_DONE; a follow-up with the same N re-issues the write.
- `n_reset` low during the STROBE phase of WRITE_A → `swr` 0 with no clock edge; after release `req_ready` 1; same N then performs the full sequence (cache empty).
